sin_lut_arb: RTL and testbench
==============================

SIN_LUT_ARB -- requirements
Module: sin_lut_arb

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one sine LUT read port.
REQ-002 Parameter ADDR_BITS, default 9: LUT address width (512-entry table).
REQ-003 Parameter DATA_BITS, default 16: LUT sample width.
REQ-004 Port clk  input  1: single clock; all logic SHALL be on its rising edge.
REQ-005 Port reset  input  1: asynchronous, active-high reset.
REQ-006 Port en  input  1: arbitration enable; when low, no new grants SHALL be issued.
REQ-007 Port req  input  N_REQ: per-requester read request, level, held until granted.
REQ-008 Port addr  input  N_REQ*ADDR_BITS: flattened per-requester addresses; requester i uses bits [i*ADDR_BITS +: ADDR_BITS], held stable while req[i] is high.
REQ-009 Port gnt  output  N_REQ: one-hot, one-cycle grant pulse, registered.
REQ-010 Port lut_en  output  1: LUT read strobe, registered.
REQ-011 Port lut_addr  output  ADDR_BITS: LUT read address, registered.
REQ-012 Port lut_q  input  DATA_BITS: LUT data, valid exactly 1 cycle after lut_en.
REQ-013 Port rd_valid  output  N_REQ: one-hot, one-cycle pulse marking rd_data for that requester.
REQ-014 Port rd_data  output  DATA_BITS: registered read data, broadcast to all requesters.
REQ-015 Port conflict_cnt  output  16: saturating count of cycles with two or more eligible requests.

Function
REQ-016 Eligible set in cycle T SHALL be req & ~gnt (a requester whose gnt is high in T is masked in T).
REQ-017 If en=1 and the eligible set is non-empty in cycle T, exactly one requester SHALL be selected by round-robin starting at pointer rr; gnt, lut_en and lut_addr=addr[sel] SHALL be asserted in T+1.
REQ-018 rr SHALL update to (sel+1) mod N_REQ on each grant; it SHALL be unchanged when nothing is granted.
REQ-019 Round-robin search order SHALL be rr, rr+1, ..., wrapping from N_REQ-1 to 0.
REQ-020 lut_en SHALL be high only in cycles where some gnt bit is high; lut_addr SHALL hold its previous value when lut_en=0.
REQ-021 Requester id SHALL be pipelined alongside the read; in T+2 the block SHALL capture lut_q into rd_data and assert rd_valid[sel] in T+3 (grant-to-data latency 2 cycles).
REQ-022 Throughput SHALL be one grant per cycle; back-to-back grants to different requesters SHALL produce back-to-back rd_valid pulses in the same order.
REQ-023 rd_data SHALL hold its value when rd_valid is all-zero.
REQ-024 en falling SHALL NOT cancel grants already issued; in-flight reads SHALL complete and produce rd_valid.
REQ-025 req dropping before grant SHALL withdraw the request with no grant and no error.
REQ-026 conflict_cnt SHALL increment by 1 in each cycle where en=1 and popcount(eligible set) >= 2; it SHALL saturate at 16'hFFFF.
REQ-027 N_REQ=1 SHALL degenerate to grant-whenever-eligible with rr fixed at 0.

Reset
REQ-028 While reset=1: gnt=0, lut_en=0, lut_addr=0, rd_valid=0, rd_data=0, conflict_cnt=0, rr=0, pipeline id/valid stages cleared.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight reads; no rd_valid SHALL appear for requests granted before reset.
REQ-030 First grant after reset release SHALL occur no earlier than the cycle after the first rising edge sampling reset=0 with an eligible request.

Verification
REQ-031 Single requester: req[2]=1, addr2=9'h040 at T, lut_q model returns 16'h1234 -> gnt=4'b0100 and lut_addr=9'h040 at T+1, rd_valid=4'b0100 with rd_data=16'h1234 at T+3.
REQ-032 All four req held continuously after reset -> grants in order 0,1,2,3,0 on consecutive cycles; conflict_cnt increments every cycle with >=2 eligible requesters.
REQ-033 req[1] and req[3] only, rr=2 -> gnt[3] first, then gnt[1]; rd_valid order 3 then 1.
REQ-034 en=0 with req=4'b1111 for 10 cycles -> gnt=0, lut_en=0, conflict_cnt unchanged; en=1 -> grant resumes from saved rr.
REQ-035 Reset pulse one cycle after gnt[0] -> rd_valid stays 0, all outputs zero, rr=0.
REQ-036 Force conflict_cnt to 16'hFFFE and hold contention 3 cycles -> value reads 16'hFFFF and stays.

Source files
------------

// File: rtl/sin_lut_arb_if.sv
// Requester/LUT bus for sin_lut_arb: per-requester request, address and grant,
// the shared LUT read port, and the broadcast read-data return path.
interface sin_lut_arb_if #(
    parameter int N_REQ     = 4,
    parameter int ADDR_BITS = 9,
    parameter int DATA_BITS = 16
);
    logic [N_REQ-1:0]           req;
    logic [N_REQ*ADDR_BITS-1:0] addr;
    logic [N_REQ-1:0]           gnt;
    logic                       lut_en;
    logic [ADDR_BITS-1:0]       lut_addr;
    logic [DATA_BITS-1:0]       lut_q;
    logic [N_REQ-1:0]           rd_valid;
    logic [DATA_BITS-1:0]       rd_data;

    // Requesters plus the LUT memory on one side, the arbiter on the other.
    modport master (
        output req, addr, lut_q,
        input  gnt, lut_en, lut_addr, rd_valid, rd_data
    );

    modport slave (
        input  req, addr, lut_q,
        output gnt, lut_en, lut_addr, rd_valid, rd_data
    );
endinterface

// File: rtl/sin_lut_arb.sv
// Round-robin arbiter sharing one sine LUT read port among N_REQ requesters;
// grant-to-data latency is two cycles and the requester id travels with the read.
module sin_lut_arb #(
    parameter int N_REQ     = 4,
    parameter int ADDR_BITS = 9,
    parameter int DATA_BITS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    sin_lut_arb_if.slave      bus,
    output logic [15:0]       conflict_cnt
);
    localparam int RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [RR_W-1:0]      rr;
    logic [RR_W-1:0]      sel;
    logic [RR_W-1:0]      next_rr;
    logic                 found;
    logic                 grant;
    logic                 multi;
    logic [N_REQ-1:0]     eligible;
    logic [N_REQ-1:0]     sel_oh;
    logic [ADDR_BITS-1:0] sel_addr;
    logic [N_REQ-1:0]     rd_pend;

    // A requester granted this cycle is still showing req, so mask it out.
    assign eligible = bus.req & ~bus.gnt;
    assign grant    = en & found;
    assign multi    = $countones(eligible) > 1;
    assign sel_oh   = N_REQ'(1) << sel;
    assign sel_addr = bus.addr[int'(sel)*ADDR_BITS +: ADDR_BITS];

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        int idx;
        idx   = 0;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                sel   = RR_W'(idx);
            end
        end
    end

    always_comb begin
        next_rr = '0;
        if (int'(sel) != N_REQ - 1) next_rr = sel + RR_W'(1);
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr           <= '0;
            bus.gnt      <= '0;
            bus.lut_en   <= 1'b0;
            bus.lut_addr <= '0;
            rd_pend      <= '0;
            bus.rd_valid <= '0;
            bus.rd_data  <= '0;
            conflict_cnt <= '0;
        end else begin
            bus.gnt    <= grant ? sel_oh : '0;
            bus.lut_en <= grant;
            if (grant) begin
                bus.lut_addr <= sel_addr;
                rr           <= next_rr;
            end
            // lut_q answers the strobe one cycle later; the id follows it.
            rd_pend      <= bus.gnt;
            bus.rd_valid <= rd_pend;
            if (|rd_pend) bus.rd_data <= bus.lut_q;
            if (en && multi && conflict_cnt != 16'hFFFF)
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_sin_lut_arb.sv
// Directed bench for sin_lut_arb: stimulus pushes expected reads into a
// scoreboard, a negedge monitor pops and compares each rd_valid pulse.
module tb_sin_lut_arb;
    localparam int N  = 4;
    localparam int AB = 9;
    localparam int DB = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [15:0] conflict_cnt;

    sin_lut_arb_if #(.N_REQ(N), .ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

    sin_lut_arb #(.N_REQ(N), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .bus          (bus.slave),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  vld;
        logic [DB-1:0] data;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_fail = 0;
    logic [DB-1:0] hold_data = '0;

    function automatic logic [DB-1:0] lut_fn(logic [AB-1:0] a);
        return 16'h1234 ^ {7'd0, a} ^ 16'h0040;
    endfunction

    // Registered LUT model: data one cycle after the strobe.
    always @(posedge clk) bus.lut_q <= bus.lut_en ? lut_fn(bus.lut_addr) : 16'hDEAD;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_addr(int id, logic [AB-1:0] a);
        bus.addr[id*AB +: AB] = a;
    endtask

    task automatic expect_read(int id);
        exp_t e;
        e.vld  = N'(1) << id;
        e.data = lut_fn(bus.addr[id*AB +: AB]);
        sb.push_back(e);
    endtask

    task automatic drain();
        repeat (4) tick();
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_gnt"}, bus.gnt, 0);
        check({tag, "_lut_en"}, bus.lut_en, 0);
        check({tag, "_lut_addr"}, bus.lut_addr, 0);
        check({tag, "_rd_valid"}, bus.rd_valid, 0);
        check({tag, "_rd_data"}, bus.rd_data, 0);
        check({tag, "_conflict"}, conflict_cnt, 0);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            hold_data = '0;
        end else if (bus.rd_valid != '0) begin
            if (sb.size() == 0) begin
                check("rd_valid_unexpected", bus.rd_valid, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rd_valid", bus.rd_valid, e.vld);
                check("rd_data", bus.rd_data, e.data);
                hold_data = e.data;
            end
        end else begin
            check("rd_data_hold", bus.rd_data, hold_data);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req  = '0;
        bus.addr = '0;
        repeat (2) tick();
        check_all_zero("reset");
        reset = 1'b0;
        en    = 1'b1;

        // Single requester, LUT returns 16'h1234 for address 9'h040.
        set_addr(2, 9'h040);
        bus.req = 4'b0100;
        sb.push_back('{vld: 4'b0100, data: 16'h1234});
        tick();
        check("single_gnt", bus.gnt, 4'b0100);
        check("single_lut_en", bus.lut_en, 1);
        check("single_lut_addr", bus.lut_addr, 9'h040);
        bus.req = '0;
        tick();
        check("single_gnt_pulse", bus.gnt, 0);
        check("single_lut_en_off", bus.lut_en, 0);
        check("single_lut_addr_hold", bus.lut_addr, 9'h040);
        drain();

        // All four held: grants 0,1,2,3,0 back to back, conflict each cycle.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_addr(0, 9'h011);
        set_addr(1, 9'h122);
        set_addr(2, 9'h0A3);
        set_addr(3, 9'h1F4);
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            expect_read(i % 4);
            tick();
            check("rr_gnt", bus.gnt, 1 << (i % 4));
            check("rr_lut_addr", bus.lut_addr, bus.addr[(i % 4)*AB +: AB]);
            check("rr_conflict", conflict_cnt, i + 1);
        end
        bus.req = '0;
        tick();
        check("rr_conflict_idle", conflict_cnt, 5);
        drain();

        // en low blocks grants and counting; rr (=1) is preserved.
        en      = 1'b0;
        bus.req = 4'b1111;
        repeat (10) begin
            tick();
            check("en_off_gnt", bus.gnt, 0);
            check("en_off_lut_en", bus.lut_en, 0);
        end
        check("en_off_conflict", conflict_cnt, 5);
        check("en_off_lut_addr_hold", bus.lut_addr, 9'h011);
        en = 1'b1;
        expect_read(1);
        tick();
        check("en_resume_gnt", bus.gnt, 4'b0010);
        bus.req = '0;
        tick();
        check("en_resume_conflict", conflict_cnt, 6);
        drain();

        // req[1] and req[3] with rr=2: 3 first, then 1.
        bus.req = 4'b1010;
        expect_read(3);
        expect_read(1);
        tick();
        check("pair_gnt_first", bus.gnt, 4'b1000);
        bus.req = 4'b0010;
        tick();
        check("pair_gnt_second", bus.gnt, 4'b0010);
        bus.req = '0;
        check("pair_conflict", conflict_cnt, 7);
        drain();

        // Request withdrawn before any grant: nothing happens.
        en      = 1'b0;
        bus.req = 4'b0100;
        repeat (2) tick();
        bus.req = '0;
        en      = 1'b1;
        tick();
        check("withdraw_gnt", bus.gnt, 0);
        tick();
        check("withdraw_gnt_later", bus.gnt, 0);

        // Saturation: counter preset to FFFE under contention (rr=2).
        force dut.conflict_cnt = 16'hFFFE;
        bus.req = 4'b1111;
        expect_read(2);
        tick();
        release dut.conflict_cnt;
        for (int i = 1; i < 4; i++) begin
            expect_read((2 + i) % 4);
            tick();
            check("sat_gnt", bus.gnt, 1 << ((2 + i) % 4));
            check("sat_conflict", conflict_cnt, 16'hFFFF);
        end
        bus.req = '0;
        tick();
        check("sat_conflict_idle", conflict_cnt, 16'hFFFF);
        drain();

        // Reset one cycle after gnt[0]: in-flight read discarded, rr back to 0.
        bus.req = 4'b0001;
        tick();
        check("rst_pre_gnt", bus.gnt, 4'b0001);
        bus.req = '0;
        reset   = 1'b1;
        tick();
        check_all_zero("rst_mid");
        tick();
        reset   = 1'b0;
        bus.req = 4'b1001;
        expect_read(0);
        tick();
        check("rst_rr_gnt", bus.gnt, 4'b0001);
        bus.req = '0;
        drain();
        tick();

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
